// File: rtl/sync_fifo_mc_pkg.sv
// Shared definitions for the multi-channel synchronous FIFO.
//   addr_w / cnt_w : pointer and occupancy widths derived from the depth
//   slice_lo       : low bit index of channel ch in a flat packed bus
//   ch_status_t    : per-channel status flags
package sync_fifo_mc_pkg;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } ch_status_t;

endpackage

// File: rtl/sync_fifo_mc_ch.sv
// One first-word-fall-through FIFO channel: storage, pointers, occupancy
// counter, flags and synchronous flush.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous clear, overrides same-cycle write/read
//   wr_vld/wr_data      write request and data; wr_rdy = not full
//   rd_rdy              read request; rd_vld = not empty, rd_data = head
//   af_lvl/ae_lvl       almost-full / almost-empty thresholds
//   status              {full, empty, almostfull, almostempty}
//   level               registered occupancy (SYNC_FIFO_MC_LEVEL_EN only)
module sync_fifo_mc_ch
  import sync_fifo_mc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = addr_w(DEPTH),
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_data,
  output logic          wr_rdy,
  input  logic          rd_rdy,
  output logic          rd_vld,
  output logic [DW-1:0] rd_data,
  input  logic [CW-1:0] af_lvl,
  input  logic [CW-1:0] ae_lvl,
  output ch_status_t    status
`ifdef SYNC_FIFO_MC_LEVEL_EN
  ,
  output logic [CW-1:0] level
`endif
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          full, empty, wr_fire, rd_fire;

  // Flags come only from the registered count, never from the inputs.
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign wr_fire = wr_vld & ~full;
  assign rd_fire = rd_rdy & ~empty;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_fire) wptr <= wptr + 1'b1;
      if (rd_fire) rptr <= rptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_fire && !flush) mem[wptr] <= wr_data;
  end

  assign rd_data            = mem[rptr];
  assign wr_rdy             = ~full;
  assign rd_vld             = ~empty;
  assign status.full        = full;
  assign status.empty       = empty;
  assign status.almostfull  = (cnt >= af_lvl);
  assign status.almostempty = (cnt <= ae_lvl);

`ifdef SYNC_FIFO_MC_LEVEL_EN
  assign level = cnt;
`endif

endmodule

// File: rtl/sync_fifo_mc.sv
// Multi-channel synchronous FIFO: NUM_CH independent FWFT channels sharing
// one clock and the almost-full/almost-empty thresholds. The top only packs
// and unpacks flat buses around an array of sync_fifo_mc_ch instances.
// Optional feature macro: SYNC_FIFO_MC_LEVEL_EN adds the o_level port.
// Ports (channel c occupies [c*W +: W] of every flat bus):
//   i_clk, i_rst_n                        clock, async active-low reset
//   i_flush                               per-channel synchronous clear
//   i_valid_s, i_datain, o_ready_s        write handshake
//   i_ready_m, o_valid_m, o_dataout       read handshake, head data
//   i_almostfull_lvl, i_almostempty_lvl   shared thresholds
//   o_full, o_empty, o_almostfull, o_almostempty  per-channel flags
//   o_level                               per-channel occupancy (macro only)
module sync_fifo_mc
  import sync_fifo_mc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = addr_w(FIFO_DEPTH),
  parameter int CNT_WIDTH  = cnt_w(FIFO_DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH-1:0]            i_flush,
  input  logic [NUM_CH-1:0]            i_valid_s,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_datain,
  output logic [NUM_CH-1:0]            o_ready_s,
  input  logic [NUM_CH-1:0]            i_ready_m,
  output logic [NUM_CH-1:0]            o_valid_m,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_dataout,
  input  logic [CNT_WIDTH-1:0]         i_almostfull_lvl,
  input  logic [CNT_WIDTH-1:0]         i_almostempty_lvl,
  output logic [NUM_CH-1:0]            o_full,
  output logic [NUM_CH-1:0]            o_empty,
  output logic [NUM_CH-1:0]            o_almostfull,
  output logic [NUM_CH-1:0]            o_almostempty
`ifdef SYNC_FIFO_MC_LEVEL_EN
  ,
  output logic [NUM_CH*CNT_WIDTH-1:0]  o_level
`endif
);

  ch_status_t st [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_fifo_mc_ch #(
      .DEPTH (FIFO_DEPTH),
      .DW    (DATA_WIDTH),
      .AW    (ADDR_WIDTH),
      .CW    (CNT_WIDTH)
    ) u_ch (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .flush   (i_flush[c]),
      .wr_vld  (i_valid_s[c]),
      .wr_data (i_datain[slice_lo(c, DATA_WIDTH) +: DATA_WIDTH]),
      .wr_rdy  (o_ready_s[c]),
      .rd_rdy  (i_ready_m[c]),
      .rd_vld  (o_valid_m[c]),
      .rd_data (o_dataout[slice_lo(c, DATA_WIDTH) +: DATA_WIDTH]),
      .af_lvl  (i_almostfull_lvl),
      .ae_lvl  (i_almostempty_lvl),
      .status  (st[c])
`ifdef SYNC_FIFO_MC_LEVEL_EN
      ,
      .level   (o_level[slice_lo(c, CNT_WIDTH) +: CNT_WIDTH])
`endif
    );

    assign o_full[c]        = st[c].full;
    assign o_empty[c]       = st[c].empty;
    assign o_almostfull[c]  = st[c].almostfull;
    assign o_almostempty[c] = st[c].almostempty;
  end

endmodule

// File: tb/tb_sync_fifo_mc.sv
module tb_sync_fifo_mc;
  localparam int NC = 4, D = 16, DW = 8, CW = 5;
  localparam int AF = 14, AE = 2;

  logic              i_clk = 0, i_rst_n = 0;
  logic [NC-1:0]     i_flush = 0, i_valid_s = 0, i_ready_m = 0;
  logic [NC*DW-1:0]  i_datain = 0;
  logic [CW-1:0]     i_almostfull_lvl = CW'(AF), i_almostempty_lvl = CW'(AE);
  logic [NC-1:0]     o_ready_s, o_valid_m, o_full, o_empty, o_almostfull, o_almostempty;
  logic [NC*DW-1:0]  o_dataout;
`ifdef SYNC_FIFO_MC_LEVEL_EN
  logic [NC*CW-1:0]  o_level;
`endif

  sync_fifo_mc #(.NUM_CH(NC), .FIFO_DEPTH(D), .DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid_s(i_valid_s), .i_datain(i_datain), .o_ready_s(o_ready_s),
    .i_ready_m(i_ready_m), .o_valid_m(o_valid_m), .o_dataout(o_dataout),
    .i_almostfull_lvl(i_almostfull_lvl), .i_almostempty_lvl(i_almostempty_lvl),
    .o_full(o_full), .o_empty(o_empty), .o_almostfull(o_almostfull),
`ifdef SYNC_FIFO_MC_LEVEL_EN
    .o_level(o_level),
`endif
    .o_almostempty(o_almostempty)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, failures = 0;
  int wr_cnt [NC];
  bit count_wr = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ch%0d got=%0h expected=%0h at %0t", nm, c, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel, updated from the handshake rules.
  logic [DW-1:0] mq [NC][$];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
    end else begin
      for (int c = 0; c < NC; c++) begin
        bit wr, rd;
        wr = i_valid_s[c] && (mq[c].size() < D);
        rd = i_ready_m[c] && (mq[c].size() > 0);
        if (i_flush[c]) mq[c].delete();
        else begin
          if (rd) void'(mq[c].pop_front());
          if (wr) begin
            mq[c].push_back(i_datain[c*DW +: DW]);
            if (count_wr) wr_cnt[c]++;
          end
        end
      end
    end
  end

  // Compare process: every cycle outside reset.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      for (int c = 0; c < NC; c++) begin
        int n;
        n = mq[c].size();
        chk("empty", c, 32'(o_empty[c]), 32'(n == 0));
        chk("full", c, 32'(o_full[c]), 32'(n == D));
        chk("valid_m", c, 32'(o_valid_m[c]), 32'(n != 0));
        chk("ready_s", c, 32'(o_ready_s[c]), 32'(n != D));
        chk("almostfull", c, 32'(o_almostfull[c]), 32'(n >= AF));
        chk("almostempty", c, 32'(o_almostempty[c]), 32'(n <= AE));
        if (n > 0) chk("dataout", c, 32'(o_dataout[c*DW +: DW]), 32'(mq[c][0]));
`ifdef SYNC_FIFO_MC_LEVEL_EN
        chk("level", c, 32'(o_level[c*CW +: CW]), 32'(n));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  function automatic bit pr(input int num4);
    return $urandom_range(3) < num4;
  endfunction

  initial begin
    for (int c = 0; c < NC; c++) wr_cnt[c] = 0;
    @(negedge i_clk); @(negedge i_clk);
    // Reset state (literal expectations).
    chk("rst_empty", 0, 32'(o_empty), 32'hF);
    chk("rst_full", 0, 32'(o_full), 32'h0);
    chk("rst_ready_s", 0, 32'(o_ready_s), 32'hF);
    chk("rst_valid_m", 0, 32'(o_valid_m), 32'h0);
    chk("rst_almostempty", 0, 32'(o_almostempty), 32'hF);
    chk("rst_almostfull", 0, 32'(o_almostfull), 32'h0);
    i_almostfull_lvl = '0;
    #1 chk("rst_almostfull_lvl0", 0, 32'(o_almostfull), 32'hF);
    i_almostfull_lvl = CW'(AF);
    @(negedge i_clk);
    i_rst_n = 1;

    // 1: fill ch0 with 0x01..0x10.
    for (int i = 0; i < 16; i++) begin
      i_valid_s = 4'b0001; i_datain[7:0] = 8'(i + 1);
      tick();
      chk("t1_almostfull", 0, 32'(o_almostfull[0]), 32'(i >= 13));
      chk("t1_full", 0, 32'(o_full[0]), 32'(i == 15));
    end
    i_valid_s = 0;
    chk("t1_others_empty", 1, 32'(o_empty[3:1]), 32'h7);

    // 2: drain ch0.
    for (int i = 0; i < 16; i++) begin
      chk("t2_data", 0, 32'(o_dataout[7:0]), 32'(i + 1));
      chk("t2_almostempty", 0, 32'(o_almostempty[0]), 32'(16 - i <= 2));
      i_ready_m = 4'b0001;
      tick();
    end
    i_ready_m = 0;
    chk("t2_empty", 0, 32'(o_empty[0]), 32'h1);

    // 3: ch1 full, simultaneous write+read.
    for (int i = 0; i < 16; i++) begin
      i_valid_s = 4'b0010; i_datain[15:8] = 8'(8'h30 + i);
      tick();
    end
    i_valid_s = 4'b0010; i_ready_m = 4'b0010; i_datain[15:8] = 8'hAA;
    tick();
    i_valid_s = 0; i_ready_m = 0;
    chk("t3_not_full", 1, 32'(o_full[1]), 32'h0);
    chk("t3_head", 1, 32'(o_dataout[15:8]), 32'h31);
`ifdef SYNC_FIFO_MC_LEVEL_EN
    chk("t3_level", 1, 32'(o_level[9:5]), 32'd15);
`endif
    for (int i = 0; i < 15; i++) begin
      chk("t3_data", 1, 32'(o_dataout[15:8]), 32'(8'h31 + i));
      i_ready_m = 4'b0010;
      tick();
    end
    i_ready_m = 0;
    chk("t3_empty", 1, 32'(o_empty[1]), 32'h1);

    // 4: ch2 empty, simultaneous write+read.
    i_valid_s = 4'b0100; i_ready_m = 4'b0100; i_datain[23:16] = 8'h5C;
    tick();
    i_valid_s = 0; i_ready_m = 0;
    chk("t4_valid", 2, 32'(o_valid_m[2]), 32'h1);
    chk("t4_data", 2, 32'(o_dataout[23:16]), 32'h5C);
    i_ready_m = 4'b0100;
    tick();
    i_ready_m = 0;

    // 5: ch3 holds 5, flush with write+read while ch0 writes.
    for (int i = 0; i < 5; i++) begin
      i_valid_s = 4'b1000; i_datain[31:24] = 8'(8'h90 + i);
      tick();
    end
    i_flush = 4'b1000; i_valid_s = 4'b1001; i_ready_m = 4'b1000;
    i_datain[7:0] = 8'h77; i_datain[31:24] = 8'hEE;
    tick();
    i_flush = 0; i_valid_s = 0; i_ready_m = 0;
    chk("t5_flush_empty", 3, 32'(o_empty[3]), 32'h1);
    chk("t5_ch0_valid", 0, 32'(o_valid_m[0]), 32'h1);
    chk("t5_ch0_data", 0, 32'(o_dataout[7:0]), 32'h77);
`ifdef SYNC_FIFO_MC_LEVEL_EN
    chk("t5_ch0_level", 0, 32'(o_level[4:0]), 32'd1);
`endif
    i_flush = 4'hF;
    tick();
    i_flush = 0;

    // 6: random traffic with phase-biased rates, rare flush, one mid-run reset.
    count_wr = 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int ph;
      ph = (cyc / 150) % 3;
      for (int c = 0; c < NC; c++) begin
        i_valid_s[c] = pr(ph == 1 ? 1 : 3);
        i_ready_m[c] = pr(ph == 0 ? 1 : 3);
        i_flush[c]   = ($urandom_range(255) == 0);
        i_datain[c*DW +: DW] = 8'($urandom);
      end
      if (cyc == 1000) begin
        #2 i_rst_n = 0;
        @(negedge i_clk);
        #2 i_rst_n = 1;
      end
      tick();
    end
    i_valid_s = 0; i_ready_m = 0; i_flush = 0;
    count_wr = 0;
    tick();
    for (int c = 0; c < NC; c++)
      chk("t6_wraps_ge40", c, 32'(wr_cnt[c] / D >= 40), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
